// File: rtl/led_pkg.sv
// Shared constants and helpers for the RGB LED arbiter: source count, colour
// layout and the fixed-priority pick used at frame boundaries.
package led_pkg;

    localparam int NUM_SRC  = 3;
    localparam int COLOUR_W = 24;
    localparam int PWM_W    = 8;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        SRC_BUTTON    = 2'd0,
        SRC_HOST      = 2'd1,
        SRC_HEARTBEAT = 2'd2
    } src_e;

    // Lowest-index set bit wins; walking down from the top leaves the lowest.
    function automatic logic [NUM_SRC-1:0] pick_winner(input logic [NUM_SRC-1:0] req_i);
        logic [NUM_SRC-1:0] pick;
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/led_slew.sv
// One colour channel's duty register, stepping toward its target by at most
// FADE_STEP per enable; a step of 0 jumps straight to the target.
module led_slew
    import led_pkg::*;
#(
    parameter int FADE_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [PWM_W-1:0] target_i,
    output logic [PWM_W-1:0] duty_o
);

    localparam logic [PWM_W:0]   STEP_WIDE = (PWM_W + 1)'(FADE_STEP);
    localparam logic [PWM_W-1:0] STEP      = PWM_W'(FADE_STEP);

    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W:0]   diff;
    logic             up;

    // The distance is taken one bit wider so the close-enough test can never wrap.
    always_comb begin
        up     = target_i > duty_q;
        diff   = up ? ({1'b0, target_i} - {1'b0, duty_q})
                    : ({1'b0, duty_q} - {1'b0, target_i});
        duty_d = duty_q;
        if (en_i) begin
            if (FADE_STEP == 0 || diff <= STEP_WIDE) begin
                duty_d = target_i;
            end else if (up) begin
                duty_d = duty_q + STEP;
            end else begin
                duty_d = duty_q - STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_o = duty_q;

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares the RGB LED between three requesters; ownership and duties change
// only on PWM frame boundaries so every frame uses a single duty per colour.
module rgb_led_arbiter
    import led_pkg::*;
#(
    parameter int PWM_DIV   = 48,
    parameter int FADE_STEP = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC*COLOUR_W-1:0] colour,
    output logic [NUM_SRC-1:0]          grant,
    output logic                        pwm_r,
    output logic                        pwm_g,
    output logic                        pwm_b,
    output logic                        frame
);

    localparam int               PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_W-1:0]    cnt_q, cnt_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic                frame_q;
    logic [2:0]          pwm_q, pwm_d;

    logic                tick;
    logic                fev;
    logic [NUM_SRC-1:0]  winner;
    logic [COLOUR_W-1:0] target;
    logic [PWM_W-1:0]    duty_r, duty_g, duty_b;

    // The frame event is the tick that wraps the PWM counter; it is also the
    // only moment requests are looked at.
    always_comb begin
        tick    = (pre_q == PRE_MAX);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
        fev     = tick && (cnt_q == '1);
        winner  = pick_winner(req);
        grant_d = fev ? winner : grant_q;
        target  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winner[i]) begin
                target = colour[i*COLOUR_W +: COLOUR_W];
            end
        end
        pwm_d = {cnt_q < duty_r, cnt_q < duty_g, cnt_q < duty_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            frame_q <= 1'b0;
            pwm_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            frame_q <= fev;
            pwm_q   <= pwm_d;
        end
    end

    led_slew #(.FADE_STEP(FADE_STEP)) u_slew_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (fev),
        .target_i(target[R_LSB +: PWM_W]),
        .duty_o  (duty_r)
    );

    led_slew #(.FADE_STEP(FADE_STEP)) u_slew_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (fev),
        .target_i(target[G_LSB +: PWM_W]),
        .duty_o  (duty_g)
    );

    led_slew #(.FADE_STEP(FADE_STEP)) u_slew_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (fev),
        .target_i(target[B_LSB +: PWM_W]),
        .duty_o  (duty_b)
    );

    assign grant = grant_q;
    assign frame = frame_q;
    assign pwm_r = pwm_q[2];
    assign pwm_g = pwm_q[1];
    assign pwm_b = pwm_q[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: a jump-mode and a fading instance share all
// inputs, with PWM_DIV=1 so one frame is 256 clocks.
module tb_rgb_led_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [71:0] colour;

    logic [2:0]  grantJ, grantF;
    logic        pwmRJ, pwmGJ, pwmBJ, frameJ;
    logic        pwmRF, pwmGF, pwmBF, frameF;

    int passCount  = 0;
    int checkCount = 0;
    int expQ[$];
    int cntJ[3];
    int cntF[3];

    always #5 clk = ~clk;

    rgb_led_arbiter #(.PWM_DIV(1), .FADE_STEP(0)) dutJ (
        .clk(clk), .rst_n(rst_n), .req(req), .colour(colour),
        .grant(grantJ), .pwm_r(pwmRJ), .pwm_g(pwmGJ), .pwm_b(pwmBJ), .frame(frameJ)
    );

    rgb_led_arbiter #(.PWM_DIV(1), .FADE_STEP(16)) dutF (
        .clk(clk), .rst_n(rst_n), .req(req), .colour(colour),
        .grant(grantF), .pwm_r(pwmRF), .pwm_g(pwmGF), .pwm_b(pwmBF), .frame(frameF)
    );

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded search for the next frame pulse; a timeout is a failed check.
    task automatic waitFrame(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frameJ && cycles < 400);
        if (!frameJ) begin
            checkCount++;
            $display("[TB] FAIL frame_timeout: no frame pulse within %0d cycles", cycles);
        end
    endtask

    // Starts on a frame pulse and ends on the next, counting one frame of PWM.
    task automatic measureFrame();
        for (int c = 0; c < 3; c++) begin
            cntJ[c] = 0;
            cntF[c] = 0;
        end
        repeat (256) begin
            @(negedge clk);
            cntJ[0] += int'(pwmRJ); cntJ[1] += int'(pwmGJ); cntJ[2] += int'(pwmBJ);
            cntF[0] += int'(pwmRF); cntF[1] += int'(pwmGF); cntF[2] += int'(pwmBF);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        advance(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int cycles;
        int exp;
        logic bad;
        req    = 3'b111;
        colour = {24'h0000C0, 24'h123456, 24'hFF0080};
        rst_n  = 1'b0;
        bad    = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (grantJ !== 3'b000 || grantF !== 3'b000 || frameJ !== 1'b0 || frameF !== 1'b0 ||
                pwmRJ !== 1'b0 || pwmGJ !== 1'b0 || pwmBJ !== 1'b0 ||
                pwmRF !== 1'b0 || pwmGF !== 1'b0 || pwmBF !== 1'b0)
                bad = 1'b1;
        end
        expQ.push_back(0);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(bad) !== exp) $display("[TB] FAIL reset_hold: outputs nonzero during reset (got %0d want %0d)", bad, exp);
        else passCount++;

        rst_n = 1'b1;
        expQ.push_back(256);
        waitFrame(cycles);
        exp = expQ.pop_front();
        checkCount++;
        if (cycles !== exp) $display("[TB] FAIL first_frame: got %0d cycles want %0d", cycles, exp);
        else passCount++;

        expQ.push_back(1);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(grantJ) !== exp) $display("[TB] FAIL reset_first_grant: got %0b want %0b", grantJ, exp);
        else passCount++;
    endtask

    task automatic test_jump();
        int exp;
        expQ.push_back(255); expQ.push_back(0); expQ.push_back(128);
        expQ.push_back(16);  expQ.push_back(0); expQ.push_back(16);
        measureFrame();
        for (int c = 0; c < 3; c++) begin
            exp = expQ.pop_front();
            checkCount++;
            if (cntJ[c] !== exp) $display("[TB] FAIL jump_ch%0d: got %0d highs want %0d", c, cntJ[c], exp);
            else passCount++;
        end
        for (int c = 0; c < 3; c++) begin
            exp = expQ.pop_front();
            checkCount++;
            if (cntF[c] !== exp) $display("[TB] FAIL fade_first_ch%0d: got %0d highs want %0d", c, cntF[c], exp);
            else passCount++;
        end
    endtask

    task automatic test_priority();
        int cycles;
        int exp;
        logic bad;
        req    = 3'b101;
        colour = {24'h0000C0, 24'h123456, 24'h112233};
        doReset();
        waitFrame(cycles);
        expQ.push_back(3'b001);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(grantJ) !== exp) $display("[TB] FAIL prio_grant: got %0b want %0b", grantJ, exp);
        else passCount++;

        advance(100);
        req = 3'b100;
        bad = 1'b0;
        repeat (155) begin
            @(negedge clk);
            if (grantJ !== 3'b001) bad = 1'b1;
        end
        expQ.push_back(0);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(bad) !== exp) $display("[TB] FAIL prio_hold: grant changed mid-frame (got %0d want %0d)", bad, exp);
        else passCount++;

        @(negedge clk);
        expQ.push_back(3'b100);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(grantJ) !== exp || frameJ !== 1'b1) $display("[TB] FAIL prio_switch: grant %0b frame %0b want grant %0b frame 1", grantJ, frameJ, exp);
        else passCount++;

        expQ.push_back(0); expQ.push_back(192);
        measureFrame();
        exp = expQ.pop_front();
        checkCount++;
        if (cntJ[0] !== exp) $display("[TB] FAIL prio_red: got %0d want %0d", cntJ[0], exp);
        else passCount++;
        exp = expQ.pop_front();
        checkCount++;
        if (cntJ[2] !== exp) $display("[TB] FAIL prio_blue: got %0d want %0d", cntJ[2], exp);
        else passCount++;
    endtask

    task automatic test_fade();
        int cycles;
        int exp;
        int upSeq[6]   = '{16, 32, 48, 64, 69, 69};
        int downSeq[6] = '{69, 53, 37, 21, 5, 0};
        req    = 3'b001;
        colour = {24'h0000C0, 24'h123456, 24'h450000};
        doReset();
        waitFrame(cycles);
        for (int k = 0; k < 6; k++) begin
            expQ.push_back(upSeq[k]);
            measureFrame();
            exp = expQ.pop_front();
            checkCount++;
            if (cntF[0] !== exp) $display("[TB] FAIL fade_up%0d: got %0d want %0d", k, cntF[0], exp);
            else passCount++;
        end
        req = 3'b000;
        for (int k = 0; k < 6; k++) begin
            expQ.push_back(downSeq[k]);
            measureFrame();
            exp = expQ.pop_front();
            checkCount++;
            if (cntF[0] !== exp) $display("[TB] FAIL fade_down%0d: got %0d want %0d", k, cntF[0], exp);
            else passCount++;
        end
        expQ.push_back(0);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(grantF) !== exp) $display("[TB] FAIL fade_release: grant %0b want %0b", grantF, exp);
        else passCount++;
    endtask

    task automatic test_boundary();
        int cycles;
        int exp;
        logic bad;
        req = 3'b000;
        doReset();
        waitFrame(cycles);
        advance(255);
        req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        expQ.push_back(3'b010);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(grantJ) !== exp || frameJ !== 1'b1) $display("[TB] FAIL boundary_fev_req: grant %0b frame %0b want grant %0b frame 1", grantJ, frameJ, exp);
        else passCount++;

        advance(256);
        expQ.push_back(3'b000);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(grantJ) !== exp) $display("[TB] FAIL boundary_release: grant %0b want %0b", grantJ, exp);
        else passCount++;

        req = 3'b010;
        bad = 1'b0;
        repeat (255) begin
            @(negedge clk);
            if (grantJ !== 3'b000) bad = 1'b1;
        end
        expQ.push_back(0);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(bad) !== exp) $display("[TB] FAIL boundary_late_wait: granted early (got %0d want %0d)", bad, exp);
        else passCount++;

        @(negedge clk);
        expQ.push_back(3'b010);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(grantJ) !== exp) $display("[TB] FAIL boundary_late_grant: grant %0b want %0b", grantJ, exp);
        else passCount++;
    endtask

    task automatic test_async_reset();
        int cycles;
        int exp;
        req    = 3'b001;
        colour = {24'h0000C0, 24'h123456, 24'h800000};
        doReset();
        waitFrame(cycles);
        advance(50);
        expQ.push_back(1);
        exp = expQ.pop_front();
        checkCount++;
        if (int'(pwmRJ) !== exp) $display("[TB] FAIL async_pre_red: pwm_r %0b want %0b", pwmRJ, exp);
        else passCount++;

        #2 rst_n = 1'b0;
        #1;
        expQ.push_back(0);
        exp = expQ.pop_front();
        checkCount++;
        if (int'({grantJ, pwmRJ, pwmGJ, pwmBJ}) !== exp) $display("[TB] FAIL async_clear: grant %0b pwm %0b%0b%0b want all 0", grantJ, pwmRJ, pwmGJ, pwmBJ);
        else passCount++;

        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back(256);
        waitFrame(cycles);
        exp = expQ.pop_front();
        checkCount++;
        if (cycles !== exp) $display("[TB] FAIL async_first_frame: got %0d cycles want %0d", cycles, exp);
        else passCount++;

        expQ.push_back(16); expQ.push_back(128);
        measureFrame();
        exp = expQ.pop_front();
        checkCount++;
        if (cntF[0] !== exp) $display("[TB] FAIL async_fade_restart: got %0d want %0d", cntF[0], exp);
        else passCount++;
        exp = expQ.pop_front();
        checkCount++;
        if (cntJ[0] !== exp) $display("[TB] FAIL async_jump_red: got %0d want %0d", cntJ[0], exp);
        else passCount++;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 3'b000;
        colour = '0;
        test_reset();
        test_jump();
        test_priority();
        test_fade();
        test_boundary();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
